// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line input plus valid/ready byte output and status of the framed receiver
interface serial_frame_rx_if #(parameter int DATA_WIDTH = 8);
    logic                  serialIn;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] parallelOut;
    logic                  outValid;
    logic                  parityError;
    logic                  frameError;
    logic                  overrun;
    logic                  busy;
    modport master (
        input  serialIn, outReady,
        output parallelOut, outValid, parityError, frameError, overrun, busy
    );
    modport slave (
        output serialIn, outReady,
        input  parallelOut, outValid, parityError, frameError, overrun, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start-bit framed MSB-first deserializer with even parity, stop check and a one-entry output buffer
module serial_frame_rx #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1
) (
    input logic clock,
    input logic reset,
    serial_frame_rx_if.master bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         cnt;
    logic                  par;
    logic                  valid;
    logic                  parity_error;
    logic                  frame_error;
    logic                  overrun;
    assign bus.parallelOut = data;
    assign bus.outValid    = valid;
    assign bus.parityError = parity_error;
    assign bus.frameError  = frame_error;
    assign bus.overrun     = overrun;
    assign bus.busy        = state != IDLE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            shift        <= '0;
            data         <= '0;
            cnt          <= '0;
            par          <= 1'b0;
            valid        <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
            if (valid && bus.outReady) valid <= 1'b0;
            case (state)
                IDLE: if (!bus.serialIn) begin
                    state <= DATA;
                    cnt   <= '0;
                    par   <= 1'b0;
                end
                DATA: begin
                    shift <= {shift[DATA_WIDTH-2:0], bus.serialIn};
                    par   <= par ^ bus.serialIn;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DATA_WIDTH - 1)) state <= PARITY_EN ? PARITY : STOP;
                end
                PARITY: begin
                    par   <= par ^ bus.serialIn;
                    state <= STOP;
                end
                STOP: if (!bus.serialIn) begin
                    frame_error <= 1'b1;
                    state       <= WAIT_IDLE;
                end else if (PARITY_EN && par) begin
                    parity_error <= 1'b1;
                    state        <= IDLE;
                end else begin
                    state <= IDLE;
                    // a byte being accepted on this edge frees the buffer for the new one
                    if (!valid || bus.outReady) begin
                        data  <= shift;
                        valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                WAIT_IDLE: if (bus.serialIn) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for the parity and no-parity receiver variants
module tb_serial_frame_rx;
    logic clock = 1'b0;
    logic reset;
    int passed = 0;
    int total = 0;
    int pe8 = 0, fe8 = 0, ov8 = 0, pe0 = 0;
    logic [7:0] q8[$];
    logic [7:0] q0[$];
    logic [7:0] e8, e0;
    always #5 clock = ~clock;
    serial_frame_rx_if #(.DATA_WIDTH(8)) b8();
    serial_frame_rx_if #(.DATA_WIDTH(8)) b0();
    serial_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(1)) u8 (.clock(clock), .reset(reset), .bus(b8));
    serial_frame_rx #(.DATA_WIDTH(8), .PARITY_EN(0)) u0 (.clock(clock), .reset(reset), .bus(b0));

    // outputs sampled mid-cycle; valid&ready here means the byte is taken at the next edge
    always @(negedge clock) if (!reset) begin
        if (b8.parityError) pe8++;
        if (b8.frameError) fe8++;
        if (b8.overrun) ov8++;
        if (b0.parityError) pe0++;
        if (b8.outValid && b8.outReady) begin
            total++;
            if (q8.size() == 0) $display("FAIL byte8 unexpected got %h expected none", b8.parallelOut);
            else begin
                e8 = q8.pop_front();
                if (b8.parallelOut !== e8) $display("FAIL byte8 got %h expected %h", b8.parallelOut, e8);
                else passed++;
            end
        end
        if (b0.outValid && b0.outReady) begin
            total++;
            if (q0.size() == 0) $display("FAIL byte0 unexpected got %h expected none", b0.parallelOut);
            else begin
                e0 = q0.pop_front();
                if (b0.parallelOut !== e0) $display("FAIL byte0 got %h expected %h", b0.parallelOut, e0);
                else passed++;
            end
        end
    end

    task automatic step(input logic v);
        b8.serialIn = v;
        @(posedge clock);
        #1;
    endtask

    task automatic frame8(input logic [7:0] d, input logic bad_par, input logic stop);
        logic [10:0] bits;
        bits = {1'b0, d, ^d ^ bad_par, stop};
        for (int i = 10; i >= 0; i--) step(bits[i]);
        b8.serialIn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic clear_counts;
        pe8 = 0; fe8 = 0; ov8 = 0; pe0 = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) $display("FAIL %s got %0h expected %0h", name, got, want);
        else passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        total++;
        if ({b8.busy, b8.outValid, b8.parityError, b8.frameError, b8.overrun} !== 5'b0)
            $display("FAIL reset_flags got %b expected 00000",
                     {b8.busy, b8.outValid, b8.parityError, b8.frameError, b8.overrun});
        else passed++;
        total++;
        if (b8.parallelOut !== 8'h00) $display("FAIL reset_data got %h expected 00", b8.parallelOut);
        else passed++;
    endtask

    task automatic test_single;
        logic [10:0] bits;
        logic [12:0] vh;
        clear_counts();
        b8.outReady = 1'b1;
        bits = {1'b0, 8'h0F, 1'b0, 1'b1};
        q8.push_back(8'h0F);
        for (int k = 0; k < 13; k++) begin
            step(k < 11 ? bits[10-k] : 1'b1);
            vh[k] = b8.outValid;
        end
        total++;
        if (vh !== 13'b0_0100_0000_0000) $display("FAIL single_timing got %b expected 0010000000000", vh);
        else passed++;
        total++;
        if (pe8 + fe8 + ov8 != 0) $display("FAIL single_errors got %0d expected 0", pe8 + fe8 + ov8);
        else passed++;
        total++;
        if (q8.size() != 0) $display("FAIL single_pending got %0d expected 0", q8.size());
        else passed++;
    endtask

    task automatic test_back_to_back;
        clear_counts();
        b8.outReady = 1'b0;
        q8.push_back(8'hA5);
        frame8(8'hA5, 1'b0, 1'b1);
        frame8(8'h3C, 1'b0, 1'b1);
        idle(2);
        total++;
        if (b8.outValid !== 1'b1 || b8.parallelOut !== 8'hA5)
            $display("FAIL b2b_hold got %b/%h expected 1/a5", b8.outValid, b8.parallelOut);
        else passed++;
        total++;
        if (ov8 != 1) $display("FAIL b2b_overrun got %0d expected 1", ov8);
        else passed++;
        b8.outReady = 1'b1;
        step(1'b1);
        total++;
        if (b8.outValid !== 1'b0) $display("FAIL b2b_drain got %b expected 0", b8.outValid);
        else passed++;
        total++;
        if (q8.size() != 0) $display("FAIL b2b_pending got %0d expected 0", q8.size());
        else passed++;
    endtask

    task automatic test_parity;
        clear_counts();
        b8.outReady = 1'b1;
        frame8(8'h01, 1'b1, 1'b1);
        idle(2);
        total++;
        if (pe8 != 1 || fe8 != 0 || ov8 != 0)
            $display("FAIL parity_pulses got pe=%0d fe=%0d ov=%0d expected pe=1 fe=0 ov=0", pe8, fe8, ov8);
        else passed++;
        total++;
        if (b8.outValid !== 1'b0) $display("FAIL parity_valid got %b expected 0", b8.outValid);
        else passed++;
        q8.push_back(8'h55);
        frame8(8'h55, 1'b0, 1'b1);
        idle(2);
        total++;
        if (q8.size() != 0) $display("FAIL parity_next_pending got %0d expected 0", q8.size());
        else passed++;
    endtask

    task automatic test_frame_error;
        int busy_low;
        clear_counts();
        b8.outReady = 1'b1;
        busy_low = 0;
        frame8(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (b8.busy !== 1'b1 || b8.outValid !== 1'b0) busy_low++;
        end
        total++;
        if (busy_low != 0) $display("FAIL ferr_wait got %0d bad cycles expected 0", busy_low);
        else passed++;
        step(1'b1);
        total++;
        if (b8.busy !== 1'b0) $display("FAIL ferr_idle got %b expected 0", b8.busy);
        else passed++;
        total++;
        if (fe8 != 1 || pe8 != 0) $display("FAIL ferr_pulses got fe=%0d pe=%0d expected fe=1 pe=0", fe8, pe8);
        else passed++;
        q8.push_back(8'hC3);
        frame8(8'hC3, 1'b0, 1'b1);
        idle(2);
        check("ferr_next_pending", q8.size(), 0);
    endtask

    task automatic test_mid_reset;
        logic [4:0] head;
        clear_counts();
        b8.outReady = 1'b0;
        q8.push_back(8'hC3);
        frame8(8'hC3, 1'b0, 1'b1);
        idle(1);
        head = 5'b0_0111;
        for (int i = 4; i >= 0; i--) step(head[i]);
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        check("mreset_state", {b8.busy, b8.outValid, b8.parallelOut}, 10'h0);
        q8.delete();
        b8.outReady = 1'b1;
        idle(8);
        check("mreset_silent", {b8.outValid, 8'(pe8 + fe8 + ov8)}, 9'h0);
        q8.push_back(8'h99);
        frame8(8'h99, 1'b0, 1'b1);
        idle(2);
        check("mreset_next_pending", q8.size(), 0);
    endtask

    task automatic test_no_parity;
        logic [9:0] bits;
        logic [11:0] vh;
        clear_counts();
        b0.outReady = 1'b1;
        bits = {1'b0, 8'hF0, 1'b1};
        q0.push_back(8'hF0);
        for (int k = 0; k < 12; k++) begin
            b0.serialIn = k < 10 ? bits[9-k] : 1'b1;
            @(posedge clock);
            #1;
            vh[k] = b0.outValid;
        end
        b0.serialIn = 1'b1;
        check("nopar_timing", vh, 12'b0010_0000_0000);
        check("nopar_perr", pe0, 0);
        check("nopar_pending", q0.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        b8.serialIn = 1'b1;
        b8.outReady = 1'b0;
        b0.serialIn = 1'b1;
        b0.outReady = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_frame_error();
        test_mid_reset();
        test_no_parity();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
